mem_port_arbiter: RTL and testbench

Single-clock arbiter that shares the CPU's single-port 1024×32 unified memory between three requesters: instruction fetch (IF), data load/store (DATA), and an external program/debug loader (DBG). It accepts one access per cycle, drives the memory port, and routes the one-cycle-latency read data back to the owner. It sits between the pipeline stages and the memory array and replaces direct `Mem[]` indexing from the IF and MEM stages.

---
 rtl/mem_arb_pkg.sv | 29 ++
 rtl/arb_prio_sel.sv | 33 +++
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter: default geometry,
// read-return owner tags and a grant-to-owner helper.
package mem_arb_pkg;

  localparam int MEM_AW    = 10;
  localparam int MEM_DW    = 32;
  localparam int MEM_DEPTH = 1024;

  // Who the read data coming back next cycle belongs to.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2,
    OWN_DBG  = 2'd3
  } arb_owner_t;

  // Grant vector bit order is {dbg, dm, if}.
  function automatic arb_owner_t gnt_to_owner(input logic [2:0] gnt);
    arb_owner_t own;
    case (gnt)
      3'b001:  own = OWN_IF;
      3'b010:  own = OWN_DM;
      3'b100:  own = OWN_DBG;
      default: own = OWN_NONE;
    endcase
    return own;
  endfunction

endpackage

// File: rtl/arb_prio_sel.sv
// Combinational priority picker. DBG always wins; while halted nothing else
// is granted; otherwise DATA beats IF unless IF has been promoted by aging.
// Grant is one-hot in {dbg, dm, if} order.
module arb_prio_sel
  import mem_arb_pkg::*;
(
  input  logic       if_req,
  input  logic       dm_req,
  input  logic       dbg_req,
  input  logic       halted,
  input  logic       if_promote,
  output logic [2:0] gnt
);

  // Fixed-priority selection with optional IF promotion over DATA.
  always_comb begin
    gnt = 3'b000;
    if (dbg_req) begin
      gnt = 3'b100;
    end else if (halted) begin
      gnt = 3'b000;
    end else if (if_promote && if_req) begin
      gnt = 3'b001;
    end else if (dm_req) begin
      gnt = 3'b010;
    end else if (if_req) begin
      gnt = 3'b001;
    end else begin
      gnt = 3'b000;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the single-port unified memory between instruction fetch,
// data load/store and the debug loader. One access per cycle, issued in the
// grant cycle; read data is routed back to its owner one cycle later.
// Optional feature macro: MEM_ARB_AGING_EN (IF starvation guard by aging).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = MEM_AW,
  parameter int DW      = MEM_DW,
  parameter int DEPTH   = MEM_DEPTH,
  parameter int AGE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          halted,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          addr_err
);

  // One extra bit so DEPTH == 2**AW is representable.
  localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

  logic [2:0]    gnt_s;
  logic          any_gnt_s;
  logic          if_promote_s;
  logic [AW-1:0] sel_addr_s;
  logic          sel_we_s;
  logic [DW-1:0] sel_wdata_s;
  arb_owner_t    owner_r;
  logic          err_r;

  // Requests are masked during reset so no grant or port activity leaks out.
  arb_prio_sel u_prio_sel (
    .if_req     (if_req  & rst_n),
    .dm_req     (dm_req  & rst_n),
    .dbg_req    (dbg_req & rst_n),
    .halted     (halted),
    .if_promote (if_promote_s),
    .gnt        (gnt_s)
  );

  assign if_gnt    = gnt_s[0];
  assign dm_gnt    = gnt_s[1];
  assign dbg_gnt   = gnt_s[2];
  assign any_gnt_s = |gnt_s;

`ifdef MEM_ARB_AGING_EN
  localparam int AGE_W = $clog2(AGE_MAX + 1);
  logic [AGE_W-1:0] age_cnt;

  // Count consecutive denied IF cycles, saturating at AGE_MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_cnt <= '0;
    end else if (if_gnt) begin
      age_cnt <= '0;
    end else if (if_req && (age_cnt != AGE_W'(AGE_MAX))) begin
      age_cnt <= age_cnt + AGE_W'(1);
    end else begin
      age_cnt <= age_cnt;
    end
  end

  assign if_promote_s = (age_cnt == AGE_W'(AGE_MAX));
`else
  // No aging in this build: IF is never promoted (AGE_MAX has no effect).
  assign if_promote_s = (AGE_MAX < 0);
`endif

  // Route the winning requester onto the shared port.
  always_comb begin
    sel_addr_s  = '0;
    sel_we_s    = 1'b0;
    sel_wdata_s = '0;
    case (gnt_s)
      3'b001: begin
        sel_addr_s = if_addr;
      end
      3'b010: begin
        sel_addr_s  = dm_addr;
        sel_we_s    = dm_we;
        sel_wdata_s = dm_wdata;
      end
      3'b100: begin
        sel_addr_s  = dbg_addr;
        sel_we_s    = dbg_we;
        sel_wdata_s = dbg_wdata;
      end
      default: begin
        sel_addr_s  = '0;
        sel_we_s    = 1'b0;
        sel_wdata_s = '0;
      end
    endcase
  end

  // Out-of-range grants are flagged and never reach the memory array.
  always_comb begin
    addr_err  = any_gnt_s && ({1'b0, sel_addr_s} >= DEPTH_LIM);
    mem_en    = any_gnt_s && !addr_err;
    mem_we    = mem_en && sel_we_s;
    mem_addr  = mem_en ? sel_addr_s : '0;
    mem_wdata = mem_we ? sel_wdata_s : '0;
  end

  // Remember which requester owns next cycle's read data (reads only).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_r <= OWN_NONE;
      err_r   <= 1'b0;
    end else if (any_gnt_s && !sel_we_s) begin
      owner_r <= gnt_to_owner(gnt_s);
      err_r   <= addr_err;
    end else begin
      owner_r <= OWN_NONE;
      err_r   <= 1'b0;
    end
  end

  // Steer returning data to its owner; everyone else sees zero, and a
  // failed-address read returns zero with valid still asserted.
  always_comb begin
    if_rvalid  = (owner_r == OWN_IF);
    dm_rvalid  = (owner_r == OWN_DM);
    dbg_rvalid = (owner_r == OWN_DBG);
    if_rdata   = (if_rvalid  && !err_r) ? mem_rdata : '0;
    dm_rdata   = (dm_rvalid  && !err_r) ? mem_rdata : '0;
    dbg_rdata  = (dbg_rvalid && !err_r) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed sequences, a vector
// table and randomized traffic checked against a behavioural model.
// Honours MEM_ARB_AGING_EN the same way the design does.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW      = 11;
  localparam int DW      = 32;
  localparam int DEPTH   = 1024;
  localparam int AGE_MAX = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          halted = 1'b0;
  logic          if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic          dbg_req = 1'b0, dbg_we = 1'b0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0, dbg_addr = '0;
  logic [DW-1:0] dm_wdata = '0, dbg_wdata = '0;
  logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid, dbg_gnt, dbg_rvalid;
  logic [DW-1:0] if_rdata, dm_rdata, dbg_rdata;
  logic          mem_en, mem_we, addr_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .AGE_MAX(AGE_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .halted(halted),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .addr_err(addr_err)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 5) return 32'hDEADBEEF;
    return 32'h1000_0000 + DW'(i) * 32'h0001_0003;
  endfunction

  // Memory array attached to the port: one-cycle read latency.
  logic [DW-1:0] tmem [DEPTH];
  bit            tmem_ready = 1'b0;
  always @(posedge clk) begin
    if (!tmem_ready) begin
      for (int i = 0; i < DEPTH; i++) tmem[i] <= init_word(i);
      mem_rdata  <= '0;
      tmem_ready <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) tmem[mem_addr[9:0]] <= mem_wdata;
      else        mem_rdata <= tmem[mem_addr[9:0]];
    end
  end

  typedef struct {
    logic          rst_n;
    logic          halted;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
  } stim_t;

  typedef struct {
    stim_t         s;
    logic [2:0]    eg;   // expected {dbg,dm,if} grant
    logic          ee;   // expected addr_err
    logic [2:0]    ev;   // expected {dbg,dm,if} rvalid
    logic [DW-1:0] ed;   // expected OR of all rdata
  } row_t;

  // Behavioural model state.
  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] ref_mem [DEPTH];
  int            age = 0;
  int            pend_own = 0;       // 0 none, 1 IF, 2 DATA, 3 DBG
  logic [DW-1:0] pend_data = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic stim_t mk(input int h, input int ifr, input int ifa,
                               input int dmr, input int dmw, input int dma, input logic [DW-1:0] dmd,
                               input int dbr, input int dbw, input int dba, input logic [DW-1:0] dbd);
    stim_t s;
    s.rst_n = 1'b1;           s.halted = (h != 0);
    s.if_req = (ifr != 0);    s.if_addr = AW'(ifa);
    s.dm_req = (dmr != 0);    s.dm_we = (dmw != 0);
    s.dm_addr = AW'(dma);     s.dm_wdata = dmd;
    s.dbg_req = (dbr != 0);   s.dbg_we = (dbw != 0);
    s.dbg_addr = AW'(dba);    s.dbg_wdata = dbd;
    return s;
  endfunction

  function automatic stim_t idle();
    return mk(0, 0, 0, 0, 0, 0, '0, 0, 0, 0, '0);
  endfunction

  // Winner by walking the priority list; 0 = none, 1 IF, 2 DATA, 3 DBG.
  function automatic int pick(input stim_t s, input bit promote);
    int order[3];
    bit req[4];
    req[0] = 1'b0; req[1] = s.if_req; req[2] = s.dm_req; req[3] = s.dbg_req;
    if (!s.rst_n) return 0;
    if (promote) order = '{3, 1, 2};
    else         order = '{3, 2, 1};
    foreach (order[k])
      if (req[order[k]] && (order[k] == 3 || !s.halted)) return order[k];
    return 0;
  endfunction

  // One clock cycle: drive at the falling edge, check, advance the model.
  task automatic step(input stim_t s);
    int            w;
    bit            promote;
    logic [AW-1:0] a;
    logic          we, err, hit;
    logic [DW-1:0] wd;
    logic [2:0]    eg;
    @(negedge clk);
    rst_n = s.rst_n;     halted = s.halted;
    if_req = s.if_req;   if_addr = s.if_addr;
    dm_req = s.dm_req;   dm_we = s.dm_we;   dm_addr = s.dm_addr;   dm_wdata = s.dm_wdata;
    dbg_req = s.dbg_req; dbg_we = s.dbg_we; dbg_addr = s.dbg_addr; dbg_wdata = s.dbg_wdata;
    #1;
    promote = 1'b0;
`ifdef MEM_ARB_AGING_EN
    promote = (age == AGE_MAX);
`endif
    w = pick(s, promote);
    a = '0; we = 1'b0; wd = '0;
    case (w)
      1: a = s.if_addr;
      2: begin a = s.dm_addr;  we = s.dm_we;  wd = s.dm_wdata;  end
      3: begin a = s.dbg_addr; we = s.dbg_we; wd = s.dbg_wdata; end
      default: ;
    endcase
    err = (w != 0) && (int'(a) >= DEPTH);
    hit = (w != 0) && !err;
    eg = 3'b000;
    if (w != 0) eg[w-1] = 1'b1;
    chk("gnt", {dbg_gnt, dm_gnt, if_gnt}, eg);
    chk("addr_err", addr_err, err);
    chk("mem_en", mem_en, hit);
    chk("mem_we", mem_we, hit && we);
    chk("mem_addr", mem_addr, hit ? a : '0);
    chk("mem_wdata", mem_wdata, (hit && we) ? wd : '0);
    if (!s.rst_n) pend_own = 0;
    chk("if_rvalid", if_rvalid, pend_own == 1);
    chk("dm_rvalid", dm_rvalid, pend_own == 2);
    chk("dbg_rvalid", dbg_rvalid, pend_own == 3);
    chk("if_rdata", if_rdata, (pend_own == 1) ? pend_data : '0);
    chk("dm_rdata", dm_rdata, (pend_own == 2) ? pend_data : '0);
    chk("dbg_rdata", dbg_rdata, (pend_own == 3) ? pend_data : '0);
    if (!s.rst_n) begin
      age = 0; pend_own = 0; pend_data = '0;
    end else begin
      pend_own  = (w != 0 && !we) ? w : 0;
      pend_data = (hit && !we) ? ref_mem[a[9:0]] : '0;
      if (hit && we) ref_mem[a[9:0]] = wd;
      if (w == 1) age = 0;
      else if (s.if_req && age < AGE_MAX) age++;
    end
  endtask

  row_t  tbl[13];
  stim_t s;
  int    first_if, exp_first;

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);

    // Reset held three cycles with every request high: all outputs zero.
    s = mk(0, 1, 1, 1, 0, 2, '0, 1, 0, 3, '0);
    s.rst_n = 1'b0;
    for (int k = 0; k < 3; k++) step(s);
    s.rst_n = 1'b1;
    step(s);
    chk("t1_first_gnt", {dbg_gnt, dm_gnt, if_gnt}, 3'b100);

    // DATA read of 5 contends with IF read of 6; IF follows one cycle later.
    step(mk(0, 1, 6, 1, 0, 5, '0, 0, 0, 0, '0));
    chk("t2_dm_gnt", dm_gnt, 1'b1);
    step(mk(0, 1, 6, 0, 0, 0, '0, 0, 0, 0, '0));
    chk("t2_dm_rdata", dm_rdata, 32'hDEADBEEF);
    chk("t2_if_gnt", if_gnt, 1'b1);
    step(idle());
    chk("t2_if_rdata", if_rdata, init_word(6));

    // Vector table: halted DBG access, boundary addresses, halt after a read.
    tbl[0]  = '{mk(1, 1, 3, 1, 0, 4, '0, 1, 1, 10, 32'h12345678), 3'b100, 1'b0, 3'b000, 32'h0};
    tbl[1]  = '{mk(1, 1, 3, 1, 0, 4, '0, 1, 0, 10, '0),           3'b100, 1'b0, 3'b000, 32'h0};
    tbl[2]  = '{mk(0, 0, 0, 1, 0, 1023, '0, 0, 0, 0, '0),         3'b010, 1'b0, 3'b100, 32'h12345678};
    tbl[3]  = '{mk(0, 0, 0, 1, 0, 1024, '0, 0, 0, 0, '0),         3'b010, 1'b1, 3'b010, init_word(1023)};
    tbl[4]  = '{idle(),                                           3'b000, 1'b0, 3'b010, 32'h0};
    tbl[5]  = '{mk(0, 1, 7, 0, 0, 0, '0, 0, 0, 0, '0),            3'b001, 1'b0, 3'b000, 32'h0};
    tbl[6]  = '{mk(0, 1, 8, 1, 1, 20, 32'hCAFEF00D, 0, 0, 0, '0), 3'b010, 1'b0, 3'b001, init_word(7)};
    tbl[7]  = '{mk(0, 0, 0, 1, 0, 20, '0, 0, 0, 0, '0),           3'b010, 1'b0, 3'b000, 32'h0};
    tbl[8]  = '{idle(),                                           3'b000, 1'b0, 3'b010, 32'hCAFEF00D};
    tbl[9]  = '{mk(0, 0, 0, 0, 0, 0, '0, 1, 1, 1500, 32'h55AA55AA), 3'b100, 1'b1, 3'b000, 32'h0};
    tbl[10] = '{idle(),                                           3'b000, 1'b0, 3'b000, 32'h0};
    tbl[11] = '{mk(0, 1, 9, 0, 0, 0, '0, 0, 0, 0, '0),            3'b001, 1'b0, 3'b000, 32'h0};
    tbl[12] = '{mk(1, 0, 0, 0, 0, 0, '0, 0, 0, 0, '0),            3'b000, 1'b0, 3'b001, init_word(9)};
    foreach (tbl[r]) begin
      step(tbl[r].s);
      chk("tbl_gnt", {dbg_gnt, dm_gnt, if_gnt}, tbl[r].eg);
      chk("tbl_err", addr_err, tbl[r].ee);
      chk("tbl_rvalid", {dbg_rvalid, dm_rvalid, if_rvalid}, tbl[r].ev);
      chk("tbl_rdata", if_rdata | dm_rdata | dbg_rdata, tbl[r].ed);
    end

    // Continuous DATA and IF traffic: aging lets IF through on the 5th cycle.
    first_if = 0;
    for (int k = 1; k <= 8; k++) begin
      step(mk(0, 1, 12, 1, 0, k, '0, 0, 0, 0, '0));
      if (if_gnt && first_if == 0) first_if = k;
    end
`ifdef MEM_ARB_AGING_EN
    exp_first = 5;
`else
    exp_first = 0;
`endif
    chk("t3_first_if_gnt", 64'(first_if), 64'(exp_first));

    // Randomized traffic against the model, with occasional resets.
    for (int n = 0; n < 400; n++) begin
      s.rst_n     = ($urandom_range(0, 63) != 0);
      s.halted    = ($urandom_range(0, 3) == 0);
      s.if_req    = 1'($urandom_range(0, 1));
      s.if_addr   = AW'($urandom_range(0, 1039));
      s.dm_req    = 1'($urandom_range(0, 1));
      s.dm_we     = 1'($urandom_range(0, 1));
      s.dm_addr   = AW'($urandom_range(0, 1039));
      s.dm_wdata  = $urandom();
      s.dbg_req   = ($urandom_range(0, 3) == 0);
      s.dbg_we    = 1'($urandom_range(0, 1));
      s.dbg_addr  = AW'($urandom_range(0, 1039));
      s.dbg_wdata = $urandom();
      step(s);
    end

    // Reset right after a DBG read grant: its return is dropped for good.
    step(mk(0, 0, 0, 0, 0, 0, '0, 1, 0, 5, '0));
    chk("t6_dbg_gnt", dbg_gnt, 1'b1);
    s = idle();
    s.rst_n = 1'b0;
    step(s);
    chk("t6_rvalid_in_rst", dbg_rvalid, 1'b0);
    chk("t6_rdata_in_rst", dbg_rdata, 32'h0);
    step(idle());
    chk("t6_no_replay", dbg_rvalid, 1'b0);
    step(idle());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
